// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word requests to instruction memory under a
// credit limit, buffers responses with their PCs and presents them to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t          state, state_n;
    logic [31:0]     pc, pc_n;
    logic [CW-1:0]   in_flight, in_flight_n, drop_cnt, drop_n, fifo_cnt, fifo_cnt_n;
    logic [AW-1:0]   f_rd, f_rd_n, f_wr, f_wr_n, q_rd, q_rd_n, q_wr, q_wr_n;
    logic [31:0]     f_data [FIFO_DEPTH];
    logic [31:0]     f_pc   [FIFO_DEPTH];
    logic [31:0]     q_pc   [FIFO_DEPTH];
    logic [CW:0]     occ;
    logic            pop, req_ok, acc, push;

    assign imem_req_valid = req_ok;
    assign imem_req_addr  = pc;

    // Credit counts the slot freed by a pop this cycle so a 1-cycle memory streams back to back.
    always_comb begin
        pop    = instr_valid && instr_ready;
        occ    = (CW+1)'(in_flight) + (CW+1)'(fifo_cnt) - (CW+1)'(pop);
        req_ok = (state == RUN) && (occ < (CW+1)'(FIFO_DEPTH));
        acc    = req_ok && imem_req_ready;
        push   = imem_resp_valid && !redirect_valid && (drop_cnt == '0) && (state == RUN);
    end

    always_comb begin
        state_n = state;
        drop_n  = drop_cnt;
        if (redirect_valid) begin
            drop_n = drop_cnt + in_flight + CW'(acc) - CW'(imem_resp_valid);
        end else if (imem_resp_valid && drop_cnt != '0) begin
            drop_n = drop_cnt - CW'(1);
        end
        case (state)
            BOOT:    state_n = RUN;
            RUN:     if (redirect_valid && drop_n != '0) state_n = DRAIN;
            DRAIN:   if (drop_n == '0) state_n = RUN;
            default: state_n = BOOT;
        endcase
    end

    always_comb begin
        pc_n        = pc;
        in_flight_n = in_flight + CW'(acc) - CW'(push);
        fifo_cnt_n  = fifo_cnt + CW'(push) - CW'(pop);
        f_rd_n      = f_rd + AW'(pop);
        f_wr_n      = f_wr + AW'(push);
        q_rd_n      = q_rd + AW'(push);
        q_wr_n      = q_wr + AW'(acc);
        if (acc) pc_n = pc + 32'd4;
        if (redirect_valid) begin
            pc_n        = {redirect_pc[31:2], 2'b00};
            in_flight_n = '0;
            fifo_cnt_n  = '0;
            f_rd_n      = '0;
            f_wr_n      = '0;
            q_rd_n      = '0;
            q_wr_n      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
            fifo_cnt  <= '0;
            f_rd      <= '0;
            f_wr      <= '0;
            q_rd      <= '0;
            q_wr      <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            in_flight <= in_flight_n;
            drop_cnt  <= drop_n;
            fifo_cnt  <= fifo_cnt_n;
            f_rd      <= f_rd_n;
            f_wr      <= f_wr_n;
            q_rd      <= q_rd_n;
            q_wr      <= q_wr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) q_pc[q_wr] <= pc;
        if (push) begin
            f_data[f_wr] <= imem_resp_data;
            f_pc[f_wr]   <= q_pc[q_rd];
        end
    end

    // Output register mirrors the next FIFO head; an entry pushed into an empty FIFO bypasses storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
            instr_pc    <= '0;
        end else if (fifo_cnt_n == '0) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
            instr_pc    <= '0;
        end else if (fifo_cnt - CW'(pop) == '0) begin
            instr_valid <= 1'b1;
            instr       <= imem_resp_data;
            instr_pc    <= q_pc[q_rd];
        end else begin
            instr_valid <= 1'b1;
            instr       <= f_data[f_rd_n];
            instr_pc    <= f_pc[f_rd_n];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_cnt == CW'(FIFO_DEPTH) && !pop));

endmodule
